// File: rtl/bench_run_ctrl.sv
// Run controller for the simulation bench: sequences DUT reset, counts run cycles,
// gates waveform dumping and arbitrates monitor completion requests into one finish pulse.
module bench_run_ctrl #(
    parameter int NREQ         = 4,
    parameter int CW           = 32,
    parameter int RST_CYCLES   = 2,
    parameter int DRAIN_CYCLES = 4,
    parameter int SW           = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [CW-1:0]     max_cycles,
    input  logic [CW-1:0]     dump_start,
    input  logic [CW-1:0]     dump_stop,
    input  logic [NREQ-1:0]   done_req,
    input  logic [8*NREQ-1:0] done_code,
    output logic              dut_rst_n,
    output logic              running,
    output logic [CW-1:0]     cycle,
    output logic              dump_en,
    output logic              finish,
    output logic [SW-1:0]     finish_src,
    output logic [7:0]        finish_code,
    output logic              timeout
);

    localparam int PMAX = (RST_CYCLES > DRAIN_CYCLES) ? RST_CYCLES : DRAIN_CYCLES;
    localparam int PW   = $clog2(PMAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RESET = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t          state_r, state_s;
    logic [PW-1:0]   phase_cnt_r, phase_cnt_s;
    logic [CW-1:0]   cycle_r, cycle_s;
    logic [CW-1:0]   max_r, max_s;
    logic [CW-1:0]   dstart_r, dstart_s;
    logic [CW-1:0]   dstop_r, dstop_s;
    logic [SW-1:0]   src_r, src_s;
    logic [7:0]      code_r, code_s;
    logic            timeout_r, timeout_s;
    logic            dut_rst_n_r, dut_rst_n_s;
    logic            running_r, running_s;
    logic            finish_r, finish_s;
    logic [SW-1:0]   req_idx_s;

    // Lowest-index set request wins arbitration.
    function automatic logic [SW-1:0] lowest_idx(input logic [NREQ-1:0] req);
        logic [SW-1:0] idx;
        idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = SW'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Next-state and next-output decode for the run sequencer.
    always_comb begin
        state_s     = state_r;
        phase_cnt_s = phase_cnt_r;
        cycle_s     = cycle_r;
        max_s       = max_r;
        dstart_s    = dstart_r;
        dstop_s     = dstop_r;
        src_s       = src_r;
        code_s      = code_r;
        timeout_s   = timeout_r;
        dut_rst_n_s = dut_rst_n_r;
        finish_s    = 1'b0;
        req_idx_s   = lowest_idx(done_req);

        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    max_s       = max_cycles;
                    dstart_s    = dump_start;
                    dstop_s     = dump_stop;
                    src_s       = '0;
                    code_s      = 8'h00;
                    timeout_s   = 1'b0;
                    cycle_s     = '0;
                    phase_cnt_s = '0;
                    dut_rst_n_s = 1'b0;
                    state_s     = ST_RESET;
                end else begin
                    state_s = state_r;
                end
            end
            ST_RESET: begin
                if (phase_cnt_r == PW'(RST_CYCLES - 1)) begin
                    cycle_s     = '0;
                    dut_rst_n_s = 1'b1;
                    state_s     = ST_RUN;
                end else begin
                    phase_cnt_s = phase_cnt_r + PW'(1);
                end
            end
            ST_RUN: begin
                // The final RUN cycle still counts, so the frozen value equals the RUN length.
                cycle_s = cycle_r + CW'(1);
                if (done_req != '0) begin
                    src_s       = req_idx_s;
                    code_s      = done_code[8*int'(req_idx_s) +: 8];
                    timeout_s   = 1'b0;
                    phase_cnt_s = '0;
                    state_s     = ST_DRAIN;
                end else if ((max_r != '0) && (cycle_r == max_r - CW'(1))) begin
                    src_s       = '0;
                    code_s      = 8'hFF;
                    timeout_s   = 1'b1;
                    phase_cnt_s = '0;
                    state_s     = ST_DRAIN;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (phase_cnt_r == PW'(DRAIN_CYCLES - 1)) begin
                    finish_s = 1'b1;
                    state_s  = ST_DONE;
                end else begin
                    phase_cnt_s = phase_cnt_r + PW'(1);
                end
            end
            default: begin
                state_s     = ST_IDLE;
                dut_rst_n_s = 1'b0;
            end
        endcase

        running_s = (state_s == ST_RUN);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_r     <= ST_IDLE;
            phase_cnt_r <= '0;
            cycle_r     <= '0;
            max_r       <= '0;
            dstart_r    <= '0;
            dstop_r     <= '0;
            src_r       <= '0;
            code_r      <= 8'h00;
            timeout_r   <= 1'b0;
            dut_rst_n_r <= 1'b0;
            running_r   <= 1'b0;
            finish_r    <= 1'b0;
        end else begin
            state_r     <= state_s;
            phase_cnt_r <= phase_cnt_s;
            cycle_r     <= cycle_s;
            max_r       <= max_s;
            dstart_r    <= dstart_s;
            dstop_r     <= dstop_s;
            src_r       <= src_s;
            code_r      <= code_s;
            timeout_r   <= timeout_s;
            dut_rst_n_r <= dut_rst_n_s;
            running_r   <= running_s;
            finish_r    <= finish_s;
        end
    end

    // An empty or inverted window never satisfies both bounds, so dumping stays off.
    assign dump_en     = running_r && (cycle_r >= dstart_r) && (cycle_r < dstop_r);
    assign dut_rst_n   = dut_rst_n_r;
    assign running     = running_r;
    assign cycle       = cycle_r;
    assign finish      = finish_r;
    assign finish_src  = src_r;
    assign finish_code = code_r;
    assign timeout     = timeout_r;

endmodule

// File: tb/tb_bench_run_ctrl.sv
// Self-checking bench for bench_run_ctrl: table-driven runs, randomized runs against a
// run-level model, and a mid-run reset sequence.
module tb_bench_run_ctrl;

    localparam int NREQ = 4;
    localparam int CW   = 32;
    localparam int RSTC = 2;
    localparam int DRC  = 4;
    localparam int SW   = 2;

    logic              CLK = 1'b0;
    logic              RST = 1'b0;
    logic              start = 1'b0;
    logic [CW-1:0]     max_cycles = '0;
    logic [CW-1:0]     dump_start = '0;
    logic [CW-1:0]     dump_stop = '0;
    logic [NREQ-1:0]   done_req = '0;
    logic [8*NREQ-1:0] done_code = '0;
    logic              dut_rst_n;
    logic              running;
    logic [CW-1:0]     cycle;
    logic              dump_en;
    logic              finish;
    logic [SW-1:0]     finish_src;
    logic [7:0]        finish_code;
    logic              timeout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] mx;
        logic [31:0] ds;
        logic [31:0] de;
        int          req_at;
        logic [3:0]  mask;
        logic [31:0] codes;
        logic [31:0] fin;
        logic [1:0]  src;
        logic [7:0]  code;
        logic        to;
    } vec_t;

    vec_t tbl[8];

    bench_run_ctrl #(
        .NREQ(NREQ), .CW(CW), .RST_CYCLES(RSTC), .DRAIN_CYCLES(DRC)
    ) dut (
        .CLK(CLK), .RST(RST), .start(start), .max_cycles(max_cycles),
        .dump_start(dump_start), .dump_stop(dump_stop), .done_req(done_req),
        .done_code(done_code), .dut_rst_n(dut_rst_n), .running(running),
        .cycle(cycle), .dump_en(dump_en), .finish(finish), .finish_src(finish_src),
        .finish_code(finish_code), .timeout(timeout)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dut_rst_n"}, 64'(dut_rst_n), 64'd0);
        chk({tag, "_running"}, 64'(running), 64'd0);
        chk({tag, "_cycle"}, 64'(cycle), 64'd0);
        chk({tag, "_dump_en"}, 64'(dump_en), 64'd0);
        chk({tag, "_finish"}, 64'(finish), 64'd0);
        chk({tag, "_src"}, 64'(finish_src), 64'd0);
        chk({tag, "_code"}, 64'(finish_code), 64'd0);
        chk({tag, "_timeout"}, 64'(timeout), 64'd0);
    endtask

    function automatic int lowest(input logic [3:0] m);
        for (int i = 0; i < 4; i++) begin
            if (m[i]) return i;
        end
        return 0;
    endfunction

    // One complete run from IDLE/DONE, checked cycle by cycle against expected results.
    task automatic do_run(input vec_t v, input bit junk);
        max_cycles = v.mx;
        dump_start = v.ds;
        dump_stop  = v.de;
        done_code  = v.codes;
        done_req   = '0;
        start      = 1'b1;
        step();
        start = 1'b0;
        chk("start_clr_code", 64'(finish_code), 64'd0);
        chk("start_clr_timeout", 64'(timeout), 64'd0);
        for (int r = 0; r < RSTC; r++) begin
            chk("reset_dut_rst_n", 64'(dut_rst_n), 64'd0);
            chk("reset_running", 64'(running), 64'd0);
            if (junk) done_req = 4'($urandom);
            step();
        end
        for (int n = 0; n < int'(v.fin); n++) begin
            done_req = (n == v.req_at) ? v.mask : 4'b0000;
            if (junk) start = 1'($urandom_range(0, 1));
            chk("run_cycle", 64'(cycle), 64'(n));
            chk("run_running", 64'(running), 64'd1);
            chk("run_dut_rst_n", 64'(dut_rst_n), 64'd1);
            chk("run_finish", 64'(finish), 64'd0);
            chk("run_dump_en", 64'(dump_en),
                64'((32'(n) >= v.ds) && (32'(n) < v.de)));
            step();
        end
        start = 1'b1;
        for (int d = 0; d < DRC; d++) begin
            if (junk) done_req = 4'($urandom);
            chk("drain_running", 64'(running), 64'd0);
            chk("drain_finish", 64'(finish), 64'd0);
            chk("drain_cycle", 64'(cycle), 64'(v.fin));
            chk("drain_src", 64'(finish_src), 64'(v.src));
            chk("drain_code", 64'(finish_code), 64'(v.code));
            chk("drain_timeout", 64'(timeout), 64'(v.to));
            chk("drain_dump_en", 64'(dump_en), 64'd0);
            step();
        end
        start    = 1'b0;
        done_req = '0;
        chk("done_finish", 64'(finish), 64'd1);
        chk("done_cycle", 64'(cycle), 64'(v.fin));
        chk("done_src", 64'(finish_src), 64'(v.src));
        chk("done_code", 64'(finish_code), 64'(v.code));
        chk("done_timeout", 64'(timeout), 64'(v.to));
        chk("done_dut_rst_n", 64'(dut_rst_n), 64'd1);
        step();
        chk("done_finish_once", 64'(finish), 64'd0);
        chk("done_hold_cycle", 64'(cycle), 64'(v.fin));
        chk("done_hold_code", 64'(finish_code), 64'(v.code));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        bit   by_req;

        tbl[0] = '{32'd10, 32'd0, 32'd0, 99, 4'b0000, 32'h0000_0000, 32'd10, 2'd0, 8'hFF, 1'b1};
        tbl[1] = '{32'd0,  32'd0, 32'd4, 5,  4'b1010, 32'h33AA_5A01, 32'd6,  2'd1, 8'h5A, 1'b0};
        tbl[2] = '{32'd10, 32'd0, 32'd0, 9,  4'b0100, 32'h0077_0000, 32'd10, 2'd2, 8'h77, 1'b0};
        tbl[3] = '{32'd20, 32'd3, 32'd6, 8,  4'b0001, 32'h0000_0011, 32'd9,  2'd0, 8'h11, 1'b0};
        tbl[4] = '{32'd8,  32'd6, 32'd3, 99, 4'b0000, 32'h1234_5678, 32'd8,  2'd0, 8'hFF, 1'b1};
        tbl[5] = '{32'd1,  32'd0, 32'd9, 99, 4'b0000, 32'h0000_0000, 32'd1,  2'd0, 8'hFF, 1'b1};
        tbl[6] = '{32'd4,  32'd0, 32'd0, 99, 4'b0000, 32'h0000_0000, 32'd4,  2'd0, 8'hFF, 1'b1};
        tbl[7] = '{32'd0,  32'd0, 32'd1, 0,  4'b1000, 32'hC300_0000, 32'd1,  2'd3, 8'hC3, 1'b0};

        RST = 1'b0;
        step();
        step();
        step();
        chk_all_zero("por");
        RST = 1'b1;
        step();
        chk("idle_dut_rst_n", 64'(dut_rst_n), 64'd0);
        chk("idle_running", 64'(running), 64'd0);

        for (int t = 0; t < 8; t++) begin
            do_run(tbl[t], 1'b0);
        end

        for (int k = 0; k < 20; k++) begin
            v.mx     = 32'($urandom_range(0, 12));
            v.ds     = 32'($urandom_range(0, 14));
            v.de     = 32'($urandom_range(0, 14));
            v.codes  = $urandom;
            v.mask   = 4'($urandom_range(0, 15));
            if (v.mx == 32'd0 && v.mask == 4'b0000) v.mask = 4'b0001;
            v.req_at = $urandom_range(0, 14);
            by_req   = (v.mask != 4'b0000) && ((v.mx == 32'd0) || (32'(v.req_at) < v.mx));
            v.fin    = by_req ? 32'(v.req_at + 1) : v.mx;
            v.src    = by_req ? 2'(lowest(v.mask)) : 2'd0;
            v.code   = by_req ? v.codes[8*lowest(v.mask) +: 8] : 8'hFF;
            v.to     = !by_req;
            do_run(v, 1'b1);
        end

        max_cycles = 32'd0;
        dump_start = 32'd0;
        dump_stop  = 32'd100;
        done_req   = '0;
        start      = 1'b1;
        step();
        start = 1'b0;
        for (int r = 0; r < RSTC; r++) step();
        for (int n = 0; n < 5; n++) step();
        chk("midrst_cycle5", 64'(cycle), 64'd5);
        chk("midrst_dump_en", 64'(dump_en), 64'd1);
        RST = 1'b0;
        step();
        chk_all_zero("midrst");
        RST      = 1'b1;
        done_req = 4'b1111;
        for (int d = 0; d < DRC + 4; d++) begin
            step();
            chk("midrst_no_finish", 64'(finish), 64'd0);
            chk("midrst_idle_running", 64'(running), 64'd0);
        end
        done_req = '0;

        do_run(tbl[6], 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
